// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM encoding, access size
// codes and the memory-mapped IO region decode.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  // Address bits [17:16] == 2'b11 select the UART / IO window.
  localparam logic [1:0] IO_REGION = 2'b11;

  // Number of bus bytes for an LS size code; unknown codes move a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size_e'(size))
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [1:0] addr_hi);
    return addr_hi == IO_REGION;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates the fetch and load/store ports onto the single
// byte-wide RAM/IO bus, serialises each request into byte accesses and
// returns the little-endian assembled word with a one-cycle done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ls_req,
  input  logic                  ls_wr,
  input  logic [1:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  state_e                state_q, state_d;
  logic [2:0]            k_q, k_d;         // byte counter 0..N
  logic [2:0]            n_q, n_d;         // bytes in this transaction
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic                  is_ls_q, is_ls_d; // 1: LS port was granted
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           asm_q, asm_d;     // read bytes assembled so far
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           ls_rdata_q, ls_rdata_d;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [1:0]            cap_sel;
  logic                  io_stall;

  assign if_data  = if_data_q;
  assign ls_rdata = ls_rdata_q;

  // State register with synchronous reset; reset discards any transaction.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      is_ls_q    <= 1'b0;
      wdata_q    <= '0;
      asm_q      <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      is_ls_q    <= is_ls_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // Next-state, byte sequencing and bus outputs.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    is_ls_d    = is_ls_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    mem_a      = '0;
    mem_dout   = '0;
    mem_wr     = 1'b0;
    if_done    = 1'b0;
    ls_done    = 1'b0;

    cur_addr = addr_q + ADDR_WIDTH'(k_q);
    cap_sel  = 2'(k_q - 3'd1);
    io_stall = is_io(cur_addr[17:16]) && io_buffer_full;

    case (state_q)
      ST_IDLE: begin
        if (rdy && ls_req) begin
          state_d = ST_BUSY;
          k_d     = '0;
          n_d     = size_bytes(ls_size);
          addr_d  = ls_addr;
          wr_d    = ls_wr;
          is_ls_d = 1'b1;
          wdata_d = ls_wdata;
          asm_d   = '0;
        end else if (rdy && if_req) begin
          state_d = ST_BUSY;
          k_d     = '0;
          n_d     = 3'd4;
          addr_d  = if_addr;
          wr_d    = 1'b0;
          is_ls_d = 1'b0;
          asm_d   = '0;
        end
      end

      ST_BUSY: begin
        if (wr_q) begin
          mem_a    = cur_addr;
          mem_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
          // A full IO buffer or a frozen pipeline holds the current byte.
          if (rdy && !io_stall) begin
            mem_wr = 1'b1;
            if (k_q == 3'(n_q - 3'd1)) state_d = ST_DONE;
            else                       k_d     = k_q + 3'd1;
          end
        end else if (!rdy) begin
          // Re-present the previous address so mem_din still carries the
          // pending byte when rdy comes back.
          mem_a = (k_q == 3'd0) ? addr_q : cur_addr - ADDR_WIDTH'(1);
        end else begin
          // Past the last byte the bus parks on address 0 so no extra IO
          // byte is consumed.
          mem_a = (k_q < n_q) ? cur_addr : '0;
          if (k_q != 3'd0) asm_d[{cap_sel, 3'b000} +: 8] = mem_din;
          if (k_q == n_q) begin
            state_d = ST_DONE;
            if (is_ls_q) ls_rdata_d = asm_d;
            else         if_data_d  = asm_d;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end

      ST_DONE: begin
        // Gated by rdy so the pulse stays one cycle even when frozen here.
        if (rdy) begin
          if_done = !is_ls_q;
          ls_done = is_ls_q;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte-addressed RAM model with one-cycle read
// latency, a table of complete transactions, and cycle-exact sequences for
// arbitration, IO stalls, rdy freezes and reset.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req = 1'b0;
  logic        ls_wr = 1'b0;
  logic [1:0]  ls_size = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int checks = 0;
  int failures = 0;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM model: read data for the address of the previous cycle; writes on strobe.
  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    mem_din <= rd_byte(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ram[a + 32'(i)] = w[8*i +: 8];
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {rd_byte(a + 32'd3), rd_byte(a + 32'd2), rd_byte(a + 32'd1), rd_byte(a)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to the next cycle; inputs are driven 2 ns after the edge and
  // outputs are sampled 1 ns later, well clear of both clock edges.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one request in a fresh IDLE cycle (cycle 0) and wait for its done.
  task automatic run_txn(input logic is_ls, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] data);
    tick();
    if (is_ls) begin
      ls_req = 1'b1; ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    lat = -1;
    data = '0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick();
      #1;
      if (is_ls ? ls_done : if_done) begin
        lat = c;
        data = is_ls ? ls_rdata : if_data;
      end
    end
    ls_req = 1'b0;
    if_req = 1'b0;
    if (lat >= 0) begin
      tick();
      #1;
      check("done_one_cycle", {31'b0, (is_ls ? ls_done : if_done)}, 32'd0);
    end
  endtask

  typedef struct packed {
    logic        is_ls;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ram_word;
    logic [31:0] exp_data;
    logic [7:0]  exp_lat;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    int lat;
    logic [31:0] data;

    // is_ls wr size addr wdata ram_word exp_data exp_lat
    vecs[0] = '{1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0,         32'h0000_0013, 32'h0000_0013, 8'd6};
    vecs[1] = '{1'b1, 1'b0, 2'd2, 32'h0000_2000, 32'h0,         32'h1234_5678, 32'h1234_5678, 8'd6};
    vecs[2] = '{1'b1, 1'b0, 2'd1, 32'h0000_1003, 32'h0,         32'hAABB_BEEF, 32'h0000_BEEF, 8'd4};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 32'h0000_4001, 32'h0,         32'h9988_77F0, 32'h0000_00F0, 8'd3};
    vecs[4] = '{1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'hDDCC_BBAA, 32'hDDCC_BBAA, 8'd6};
    vecs[5] = '{1'b1, 1'b1, 2'd2, 32'h0000_5000, 32'hCAFE_BABE, 32'h0000_0000, 32'hCAFE_BABE, 8'd5};
    vecs[6] = '{1'b1, 1'b1, 2'd1, 32'h0000_6001, 32'h1234_ABCD, 32'h1111_1111, 32'h1111_ABCD, 8'd3};
    vecs[7] = '{1'b1, 1'b1, 2'd0, 32'h0000_7000, 32'hFFFF_FF5A, 32'hFFFF_FFFF, 32'hFFFF_FF5A, 8'd2};

    // Reset state.
    tick(); tick();
    rst = 1'b0;
    tick(); #1;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_ctrl", {28'b0, mem_wr, if_done, ls_done, 1'b0}, 32'h0);
    check("rst_dout", {24'b0, mem_dout}, 32'h0);
    check("rst_data", if_data | ls_rdata, 32'h0);

    // Table of complete transactions: latency and returned / stored data.
    for (int i = 0; i < NV; i++) begin
      preload(vecs[i].addr, vecs[i].ram_word);
      run_txn(vecs[i].is_ls, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, lat, data);
      if (vecs[i].wr) data = rd_word(vecs[i].addr);
      check($sformatf("vec%0d_lat", i), 32'(lat), {24'b0, vecs[i].exp_lat});
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
    end
    check("if_data_hold", if_data, 32'hDDCC_BBAA);

    // Word fetch address trace.
    preload(32'h1000, 32'h0000_0013);
    tick();
    if_req = 1'b1; if_addr = 32'h1000;
    for (int c = 1; c <= 7; c++) begin
      tick(); #1;
      if (c <= 4) check($sformatf("fetch_a_c%0d", c), mem_a, 32'h1000 + 32'(c - 1));
      check($sformatf("fetch_done_c%0d", c), {31'b0, if_done}, {31'b0, c == 6});
      if (c == 6) begin
        check("fetch_data", if_data, 32'h0000_0013);
        if_req = 1'b0;
      end
    end

    // Simultaneous requests: LS wins, IF served after the DONE cycle.
    preload(32'h2000, 32'h1234_5678);
    tick();
    if_req = 1'b1; if_addr = 32'h1000;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h2000;
    for (int c = 1; c <= 14; c++) begin
      tick(); #1;
      check($sformatf("arb_ls_done_c%0d", c), {31'b0, ls_done}, {31'b0, c == 6});
      check($sformatf("arb_if_done_c%0d", c), {31'b0, if_done}, {31'b0, c == 13});
      if (c == 6) begin
        check("arb_ls_rdata", ls_rdata, 32'h1234_5678);
        ls_req = 1'b0;
      end
      if (c == 8) check("arb_if_a", mem_a, 32'h1000);
      if (c == 13) begin
        check("arb_if_data", if_data, 32'h0000_0013);
        if_req = 1'b0;
      end
    end

    // Byte store to IO with the buffer full for three cycles.
    tick();
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h0000_00AB;
    for (int c = 1; c <= 6; c++) begin
      tick();
      io_buffer_full = (c >= 1 && c <= 3);
      #1;
      check($sformatf("io_wr_c%0d", c), {31'b0, mem_wr}, {31'b0, c == 4});
      if (c == 4) begin
        check("io_dout", {24'b0, mem_dout}, 32'h0000_00AB);
        check("io_a", mem_a, 32'h0003_0000);
      end
      check($sformatf("io_done_c%0d", c), {31'b0, ls_done}, {31'b0, c == 5});
      if (c == 5) ls_req = 1'b0;
    end
    io_buffer_full = 1'b0;
    check("io_ram", {24'b0, rd_byte(32'h0003_0000)}, 32'h0000_00AB);

    // rdy low in cycles 3-4 of a word fetch.
    preload(32'h8000, 32'h0403_0201);
    tick();
    if_req = 1'b1; if_addr = 32'h8000;
    for (int c = 1; c <= 9; c++) begin
      tick();
      rdy = !(c == 3 || c == 4);
      #1;
      if (c == 3 || c == 4) begin
        check($sformatf("rdy_a_c%0d", c), mem_a, 32'h8001);
        check($sformatf("rdy_wr_c%0d", c), {31'b0, mem_wr}, 32'd0);
      end
      check($sformatf("rdy_done_c%0d", c), {31'b0, if_done}, {31'b0, c == 8});
      if (c == 8) begin
        check("rdy_data", if_data, 32'h0403_0201);
        if_req = 1'b0;
      end
    end
    rdy = 1'b1;

    // Reset in cycle 2 of a word store.
    tick();
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h9000; ls_wdata = 32'h1122_3344;
    tick();
    tick();
    rst = 1'b1;
    ls_req = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_a", mem_a, 32'h0);
    check("mid_rst_ctrl", {28'b0, mem_wr, if_done, ls_done, 1'b0}, 32'h0);
    check("mid_rst_dout", {24'b0, mem_dout}, 32'h0);
    check("mid_rst_data", if_data | ls_rdata, 32'h0);
    for (int c = 4; c <= 10; c++) begin
      tick(); #1;
      check($sformatf("mid_rst_no_done_c%0d", c), {31'b0, ls_done | mem_wr}, 32'd0);
    end
    preload(32'h1000, 32'h0000_0013);
    run_txn(1'b0, 1'b0, 2'd2, 32'h1000, 32'h0, lat, data);
    check("post_rst_lat", 32'(lat), 32'd6);
    check("post_rst_data", data, 32'h0000_0013);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

- Responder for the instruction-fetch request interface driven by `icache`, plus the load/store port used by the LSB.
- Serialises each granted request into byte-wide accesses on the single 8-bit RAM/IO bus, then returns the little-endian assembled word with a one-cycle done pulse.
- It is the only master of the RAM bus and sits between the cache/LSB and the top-level memory pins.

## Interface

- `ADDR_WIDTH`, 32: byte-address width on every port.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; low freezes the block.
- `if_req` in 1: fetch request, held until `if_done`.
- `if_addr` in 32: fetch byte address.
- `if_done` out 1: one-cycle pulse, `if_data` valid.
- `if_data` out 32: fetched word.
- `ls_req` in 1: load/store request, held until `ls_done`.
- `ls_wr` in 1: 1 = store, 0 = load.
- `ls_size` in 2: 0 byte, 1 half, 2 word (N = 1/2/4 bytes).
- `ls_addr` in 32: byte address.
- `ls_wdata` in 32: store data; low N bytes used.
- `ls_done` out 1: one-cycle pulse.
- `ls_rdata` out 32: load data, zero-extended.
- `mem_din` in 8: RAM read byte, for the address presented the previous cycle.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM byte address.
- `mem_wr` out 1: write strobe.
- `io_buffer_full` in 1: UART buffer full; stalls IO writes.

## Operation

- **States:** IDLE, BUSY, DONE. A byte counter k runs 0..N.
- **Reset values:** all outputs 0, state IDLE, k = 0.
- **Arbitration (IDLE only):**
  - `ls_req` has priority over `if_req`.
  - On grant, latch addr, size (a fetch is N = 4), wr and wdata; go to BUSY with k = 0.
  - Port inputs are ignored after the grant.
- **Read, BUSY:**
  - While k < N: `mem_a` = addr + k.
  - While k >= 1: capture `mem_din` as byte k-1.
  - k increments each cycle; after the k = N cycle, go to DONE.
- **Write, BUSY:**
  - `mem_wr` = 1, `mem_a` = addr + k, `mem_dout` = wdata byte k.
  - After the k = N-1 cycle, go to DONE.
- **IO stall:** if addr + k has bits [17:16] = 2'b11 and `io_buffer_full` = 1, then `mem_wr` = 0 and k holds.
- **DONE:**
  - Pulse the granted port's done for exactly one cycle, with data stable.
  - Return to IDLE. No request is accepted in the DONE cycle, so a requester that drops req on seeing done is never re-served.
- **Address arithmetic:** wraps modulo 2^32; unaligned addresses are legal, no alignment checks.
- **Data returned:**
  - `if_data` and `ls_rdata` hold their value until the next done on the same port.
  - `ls_rdata` is zero-extended; sign extension is the LSB's job.
- **Dropped request:** a req that deasserts after grant is still completed and still pulses done.
- **`mem_wr`:** 0 in IDLE and DONE.

## Timing

- Cycle 0 is the IDLE cycle in which req is sampled high.
- Read of N bytes:
  - BUSY occupies cycles 1..N+1; done is high in cycle N+2.
  - A word fetch's done is in cycle 6.
- Write of N bytes (no stalls): BUSY occupies cycles 1..N; done is in cycle N+1.
- Each IO-stall cycle adds 1.
- Back-to-back: the next grant is possible at the earliest in cycle done+1.
- **`rdy` low:**
  - State, k and captured bytes freeze; `mem_wr` is forced to 0.
  - During a read with k >= 1, `mem_a` = addr + k - 1, so `mem_din` still carries the pending byte when `rdy` returns.
  - Total latency grows by exactly the number of `rdy`-low cycles.
- **`rst` mid-transaction:** the next cycle is IDLE with all outputs 0, the transaction is discarded, and no done is issued.

## Structure

- **Shared config package/header:**
  - state encoding
  - size codes (SIZE_B/H/W)
  - IO region match (bits [17:16] = 2'b11)
- **No sub-module:** a single FSM with a byte counter and a 32-bit assembly register. Implementation target is about 150 lines.

## Test plan

- **Word fetch:** `if_req`, `if_addr` = 0x1000, RAM bytes 13 00 00 00 → `if_data` = 0x00000013; `if_done` high only in cycle 6; `mem_a` = 0x1000..0x1003 in cycles 1..4.
- **Simultaneous requests:** `if_req` and an LS load word at 0x2000 (bytes 78 56 34 12) in the same cycle → `ls_done` in cycle 6 with `ls_rdata` = 0x12345678; IF granted in cycle 7, `if_done` in cycle 13.
- **Store byte to IO:** 0xAB to 0x30000 with `io_buffer_full` high in cycles 1–3 → `mem_wr` = 0 in cycles 1–3; `mem_wr` = 1 with `mem_dout` = 0xAB in cycle 4; `ls_done` in cycle 5.
- **Unaligned half load:** at 0x1003 (bytes 0xEF, 0xBE) → `mem_a` = 0x1003 then 0x1004; `ls_rdata` = 0x0000BEEF; `ls_done` in cycle 4.
- **`rdy` low mid-read:** `rdy` low in cycles 3–4 of a word fetch → same `if_data`; done in cycle 8; `mem_a` during the stall = addr + 1.
- **Reset mid-write:** `rst` in cycle 2 of a word store → next cycle all outputs 0, no `ls_done`; a fresh fetch afterwards completes with normal latency.
